// File: rtl/fir_filter_mc_if.sv
// fir_filter_mc_if: sample, coefficient-port and result signals of fir_filter_mc.
// The filter uses the slave modport; a producer/consumer pair uses master.
interface fir_filter_mc_if #(
  parameter int TAPS        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int CHANNELS    = 2,
  parameter int OUT_WIDTH   = 16
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW  = $clog2(TAPS);

  logic                          in_valid;
  logic [CHW-1:0]                in_ch;
  logic signed [DATA_WIDTH-1:0]  in_data;
  logic                          coef_wr_en;
  logic [AW-1:0]                 coef_addr;
  logic signed [COEFF_WIDTH-1:0] coef_data;
  logic                          coef_commit;
  logic                          sat_clr;
  logic                          out_valid;
  logic [CHW-1:0]                out_ch;
  logic signed [OUT_WIDTH-1:0]   out_data;
  logic                          sat_sticky;

  modport master (
    output in_valid, in_ch, in_data, coef_wr_en, coef_addr, coef_data, coef_commit, sat_clr,
    input  out_valid, out_ch, out_data, sat_sticky
  );

  modport slave (
    input  in_valid, in_ch, in_data, coef_wr_en, coef_addr, coef_data, coef_commit, sat_clr,
    output out_valid, out_ch, out_data, sat_sticky
  );
endinterface

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: time-interleaved multi-channel pipelined FIR with double-buffered taps.
// Define FIR_MC_SAT_EN to clamp out_data and drive sat_sticky; otherwise results wrap.
module fir_filter_mc #(
  parameter int TAPS        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int CHANNELS    = 2,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SHIFT   = 14
) (
  input logic            clk,
  input logic            rst_n,
  fir_filter_mc_if.slave bus
);
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW      = $clog2(TAPS);
  localparam int PW      = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W   = PW + AW;
  localparam int NODES   = 2 * TAPS - 1;
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic [CHW:0] CH_LIMIT = (CHW + 1)'(CHANNELS);
  localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE = {2'b01, {(COEFF_WIDTH - 2){1'b0}}};
  localparam logic [ACC_W:0] RND = (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;

  // The newest sample goes straight into stage 0, so each line keeps TAPS-1 older ones.
  logic signed [DATA_WIDTH-1:0]  dl [CHANNELS][TAPS-1];
  logic signed [DATA_WIDTH-1:0]  s0_data [TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_act [TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_sh [TAPS];
  logic signed [PW-1:0]          prod [TAPS];
  logic signed [ACC_W-1:0]       node [NODES];
  logic [AW+1:0]                 vld_q;
  logic [CHW-1:0]                ch_q [AW+2];
  logic                          accept;
  logic signed [ACC_W:0]         rsum;
  logic signed [ACC_W:0]         r;
  logic                          ovf;
  logic signed [OUT_WIDTH-1:0]   res;

  assign accept = bus.in_valid && ({1'b0, bus.in_ch} < CH_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS - 1; t++)
          dl[c][t] <= '0;
      for (int t = 0; t < TAPS; t++)
        s0_data[t] <= '0;
    end else if (accept) begin
      dl[bus.in_ch][0] <= bus.in_data;
      for (int t = 1; t < TAPS - 1; t++)
        dl[bus.in_ch][t] <= dl[bus.in_ch][t-1];
      s0_data[0] <= bus.in_data;
      for (int t = 1; t < TAPS; t++)
        s0_data[t] <= dl[bus.in_ch][t-1];
    end
  end

  // A write in a commit cycle lands in shadow only because active samples the old shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TAPS; t++) begin
        coef_sh[t]  <= (t == 0) ? COEF_ONE : '0;
        coef_act[t] <= (t == 0) ? COEF_ONE : '0;
      end
    end else begin
      if (bus.coef_commit)
        for (int t = 0; t < TAPS; t++)
          coef_act[t] <= coef_sh[t];
      if (bus.coef_wr_en)
        coef_sh[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_comb begin
    for (int t = 0; t < TAPS; t++)
      prod[t] = PW'(s0_data[t]) * PW'(coef_act[t]);
  end

  // Heap-ordered tree: leaves hold registered products, node 0 is the final sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++)
        node[n] <= '0;
      vld_q <= '0;
      for (int j = 0; j < AW + 2; j++)
        ch_q[j] <= '0;
    end else begin
      for (int t = 0; t < TAPS; t++)
        node[TAPS-1+t] <= ACC_W'(prod[t]);
      for (int n = 0; n < TAPS - 1; n++)
        node[n] <= node[2*n+1] + node[2*n+2];
      vld_q   <= {vld_q[AW:0], accept};
      ch_q[0] <= bus.in_ch;
      for (int j = 1; j < AW + 2; j++)
        ch_q[j] <= ch_q[j-1];
    end
  end

  always_comb begin
    rsum = {node[0][ACC_W-1], node[0]} + $signed(RND);
    r    = rsum >>> OUT_SHIFT;
    ovf  = 1'b0;
    res  = r[OUT_WIDTH-1:0];
`ifdef FIR_MC_SAT_EN
    ovf = !((&r[ACC_W:OUT_WIDTH-1]) || !(|r[ACC_W:OUT_WIDTH-1]));
    if (ovf)
      res = r[ACC_W] ? {1'b1, {(OUT_WIDTH - 1){1'b0}}} : {1'b0, {(OUT_WIDTH - 1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= vld_q[AW+1];
      if (vld_q[AW+1]) begin
        bus.out_ch   <= ch_q[AW+1];
        bus.out_data <= res;
      end
    end
  end

`ifdef FIR_MC_SAT_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_q <= 1'b0;
    else if (vld_q[AW+1] && ovf)
      sat_q <= 1'b1;
    else if (bus.sat_clr)
      sat_q <= 1'b0;
  end

  assign bus.sat_sticky = sat_q;
`else
  logic unused_bits;
  assign unused_bits    = ^{r[ACC_W:OUT_WIDTH], ovf, bus.sat_clr};
  assign bus.sat_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_fir_filter_mc.sv
// tb_fir_filter_mc: directed table-driven check of fir_filter_mc with default parameters.
// Sequences cover impulse, ramp, interleave, saturation/wrap, commit boundary and mid-stream reset.
module tb_fir_filter_mc;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fir_filter_mc_if ifc ();

  fir_filter_mc dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  typedef struct {
    logic vld;
    logic ch;
    int   data;
    logic ev;
    logic ech;
    int   edata;
  } vec_t;

  vec_t tbl[$];
  int   sat_exp[8];
  int   stale;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic vld, input logic ch, input int data,
                               input logic wr = 1'b0, input int addr = 0, input int cdata = 0,
                               input logic commit = 1'b0, input logic clr = 1'b0);
    ifc.in_valid    = vld;
    ifc.in_ch       = ch;
    ifc.in_data     = 16'(data);
    ifc.coef_wr_en  = wr;
    ifc.coef_addr   = 3'(addr);
    ifc.coef_data   = 16'(cdata);
    ifc.coef_commit = commit;
    ifc.sat_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic ech, input int edata);
    int got;
    got = int'(ifc.out_data);
    total++;
    if (ifc.out_valid !== ev || (ev && (ifc.out_ch !== ech || got != edata))) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%0b ch=%0d data=%0d, want valid=%0b ch=%0d data=%0d",
               name, ifc.out_valid, ifc.out_ch, got, ev, ech, edata);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic void add_row(input logic vld, input logic ch, input int data,
                                  input logic ev, input logic ech, input int edata);
    tbl.push_back('{vld, ch, data, ev, ech, edata});
  endfunction

  task automatic run_table(input string sec);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].vld, tbl[i].ch, tbl[i].data);
      checkOutput($sformatf("%s[%0d]", sec, i), tbl[i].ev, tbl[i].ech, tbl[i].edata);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    ifc.in_valid    = 1'b0;
    ifc.in_ch       = 1'b0;
    ifc.in_data     = '0;
    ifc.coef_wr_en  = 1'b0;
    ifc.coef_addr   = '0;
    ifc.coef_data   = '0;
    ifc.coef_commit = 1'b0;
    ifc.sat_clr     = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // All taps at 16384 make each output the plain sum of the last eight samples.
  task automatic program_unity_taps();
    do_reset();
    for (int t = 0; t < 8; t++)
      applyStimulus(1'b0, 1'b0, 0, 1'b1, t, 16384);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    stale = 0;
    rst_n = 1'b0;
    do_reset();

    checkOutput("reset_valid", 1'b0, 1'b0, 0);
    checkVal("reset_out_data", int'(ifc.out_data), 0);
    checkVal("reset_out_ch", int'(ifc.out_ch), 0);
    checkVal("reset_sat_sticky", int'(ifc.sat_sticky), 0);

    add_row(1, 0, 1000, 0, 0, 0);
    add_row(1, 0, 0,    0, 0, 0);
    add_row(1, 0, 0,    0, 0, 0);
    add_row(1, 0, 0,    0, 0, 0);
    add_row(0, 0, 0,    0, 0, 0);
    add_row(1, 0, 0,    1, 0, 1000);
    add_row(0, 0, 0,    1, 0, 0);
    add_row(0, 0, 0,    1, 0, 0);
    add_row(0, 0, 0,    1, 0, 0);
    add_row(0, 0, 0,    0, 0, 0);
    add_row(0, 0, 0,    1, 0, 0);
    add_row(0, 0, 0,    0, 0, 0);
    run_table("impulse");

    program_unity_taps();
    for (int i = 0; i < 17; i++)
      add_row(i < 12, 0, 100, i >= 5, 0, 100 * (((i - 4) > 8) ? 8 : (i - 4)));
    run_table("ramp");

    program_unity_taps();
    for (int i = 0; i < 21; i++) begin
      int j;
      int n;
      int e;
      j = i - 5;
      if (j[0] == 1'b0) begin
        n = j / 2 + 1;
        e = 100 * ((n > 8) ? 8 : n);
      end else begin
        n = (j + 1) / 2;
        e = -50 * ((n > 8) ? 8 : n);
      end
      add_row(i < 16, i[0], i[0] ? -50 : 100, i >= 5, j[0], e);
    end
    run_table("interleave");

`ifdef FIR_MC_SAT_EN
    sat_exp = '{30000, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
`else
    sat_exp = '{30000, -5536, 24464, -11072, 18928, -16608, 13392, -22144};
`endif
    program_unity_taps();
    for (int i = 0; i < 13; i++)
      add_row(i < 8, 0, 30000, i >= 5, 0, (i >= 5) ? sat_exp[i-5] : 0);
    run_table("saturation");
`ifdef FIR_MC_SAT_EN
    checkVal("sat_sticky_set", int'(ifc.sat_sticky), 1);
`else
    checkVal("sat_sticky_wrap", int'(ifc.sat_sticky), 0);
`endif
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    checkVal("sat_sticky_clr", int'(ifc.sat_sticky), 0);

    // Commit edge c also carries a sample and a new shadow write for tap0.
    do_reset();
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 0, 8192);
    applyStimulus(1'b1, 1'b0, 1000);
    applyStimulus(1'b1, 1'b0, 1000, 1'b1, 0, 4096, 1'b1);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, -3);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("commit_before", 1'b1, 1'b0, 1000);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("commit_at", 1'b1, 1'b0, 500);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("round_pos_half", 1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("round_neg_half", 1'b1, 1'b0, -1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("commit_bubble", 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1000);
    repeat (4) applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("shadow_readback", 1'b1, 1'b0, 250);

    do_reset();
    applyStimulus(1'b1, 1'b0, 11);
    applyStimulus(1'b1, 1'b0, 22);
    applyStimulus(1'b1, 1'b0, 33);
    ifc.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkVal("midrst_valid", int'(ifc.out_valid), 0);
    checkVal("midrst_out_data", int'(ifc.out_data), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      stale += int'(ifc.out_valid);
    end
    rst_n = 1'b1;
    repeat (7) begin
      applyStimulus(1'b0, 1'b0, 0);
      stale += int'(ifc.out_valid);
    end
    checkVal("midrst_stale_outputs", stale, 0);
    applyStimulus(1'b1, 1'b1, 777);
    repeat (4) applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("post_reset_impulse", 1'b1, 1'b1, 777);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("post_reset_single", 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_filter_mc.md
# fir_filter_mc

Multi-channel, runtime-reconfigurable, pipelined N-tap FIR filter. It is the next generation of the team's fixed-coefficient FIR and adds the following:
- time-interleaved channels, each with its own delay line;
- a double-buffered coefficient bank written over a register-style port;
- valid tagging through the pipeline;
- rounding and width reduction at the output.

It sits between the sample front-end (ADC/deserializer) and downstream DSP.

## Interface
- TAPS, 8: number of taps; power of 2, ≥2.
- DATA_WIDTH, 16: signed input sample width.
- COEFF_WIDTH, 16: signed coefficient width.
- CHANNELS, 2: number of interleaved channels, ≥1.
- OUT_WIDTH, 16: signed output width.
- OUT_SHIFT, 14: right shift applied to the accumulator before output; 0 ≤ OUT_SHIFT < ACC_W.

Derived widths:
- CHW = max(1, $clog2(CHANNELS))
- ACC_W = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS)

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present this cycle.
- in_ch  in  CHW  channel of the sample.
- in_data  in  DATA_WIDTH  signed sample.
- coef_wr_en  in  1  write coef_data into shadow bank at coef_addr.
- coef_addr  in  $clog2(TAPS)  tap index.
- coef_data  in  COEFF_WIDTH  signed coefficient.
- coef_commit  in  1  copy shadow bank into active bank.
- sat_clr  in  1  clear sat_sticky.
- out_valid  out  1  out_data/out_ch valid.
- out_ch  out  CHW  channel of the result.
- out_data  out  OUT_WIDTH  signed filtered sample.
- sat_sticky  out  1  a saturation has occurred since last clear.

## Operation
- **Accept:** a sample is accepted at every edge where in_valid=1 and in_ch<CHANNELS. If in_ch≥CHANNELS the sample is dropped: no state change, no output. One sample per cycle is accepted, in any channel order.
- **Delay lines:** one delay line dl[ch][0..TAPS-1] per channel.
  - On accept, dl[ch] shifts: dl[ch][0]=in_data, dl[ch][i]=old dl[ch][i-1].
  - Other channels are untouched.
  - The shifted vector and ch are captured into pipeline stage 0.
- **Pipeline stages:**
  - Multiply stage: TAPS parallel signed products using the active bank.
  - Registered binary adder tree with $clog2(TAPS) stages, all at ACC_W, sign-extended.
  - Output stage.
- **Valid and channel tagging:** a valid bit and a channel tag travel with every stage. Bubbles, i.e. cycles with no accept, propagate as valid=0.
- **Output stage:**
  - r = (acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT, computed at ACC_W+1 bits; this is round-half-up.
  - r is then reduced to OUT_WIDTH per Configuration.
- **Coefficient banks:** active and shadow, TAPS entries each.
  - Both banks reset to tap0 = 2^(COEFF_WIDTH-2) and all other taps = 0. With default parameters this is an identity filter.
  - coef_wr_en writes the shadow bank; coef_addr≥TAPS is ignored.
  - coef_commit copies the pre-edge shadow into active. A write in the same cycle as a commit lands in shadow only and is not committed.
  - Samples accepted at edge ≥ commit edge c use the new set. Samples accepted before c use the old set; they are unaffected even while in flight.
- **sat_sticky:**
  - Set on any saturating output.
  - Cleared by sat_clr.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Latency L = $clog2(TAPS)+2 edges. A sample accepted at edge k appears with out_valid=1 after edge k+L; for TAPS=8, L=5. Throughput is 1 sample/cycle.
- Outputs are registered. out_valid is high exactly one cycle per accepted sample, in acceptance order.
- **Reset (asynchronous assert):**
  - Delay lines, pipeline data and valids are cleared.
  - Both banks return to their reset value.
  - out_valid=0, out_ch=0, out_data=0, sat_sticky=0.
- Reset mid-stream: in-flight samples are discarded and no stale output ever appears after release. The first edge after deassertion may accept a sample.
- No backpressure: the consumer must accept every out_valid cycle.

## Configuration
- FIR_MC_SAT_EN defined:
  - r outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] clamps to the nearest bound.
  - sat_sticky is set when this happens.
- FIR_MC_SAT_EN undefined:
  - out_data = r[OUT_WIDTH-1:0], i.e. two's-complement wrap.
  - sat_sticky is constant 0.

## Test plan
All scenarios use default parameters.
- **Reset impulse.** After reset, send ch0 1000 followed by zeros. Required: out_valid 5 edges after the accept, out_data=1000, out_ch=0, then 0.
- **Ramp.** Write all taps 16384, commit, then feed ch0 100 every cycle. Required: outputs 100, 200, …, 800, then a steady 800.
- **Interleave.** With coefficients as above, alternate ch0=100 and ch1=-50. Required: ch0 ramps to 800 and ch1 ramps to -400, independently; out_ch alternates; a sample with in_ch=2 (CHANNELS=3 build) or invalid-channel input produces no output.
- **Saturation.** Taps all 16384, ch0=30000 for 8 cycles.
  - With FIR_MC_SAT_EN: outputs 30000, then 32767 onward, and sat_sticky=1; sat_clr clears it.
  - Without FIR_MC_SAT_EN: the second output is -5536 and sat_sticky=0.
- **Commit boundary.** Start from the identity filter. At edge c: commit of a shadow with tap0=8192, a simultaneous write of tap0=4096, and an accepted ch0 sample 1000. Required: a sample at c-1 gives 1000, the sample at c gives 500 (rounded), and shadow tap0 reads back as 4096 after the next commit.
- **Reset mid-stream.** Assert rst_n low with 3 samples in flight. Required: out_valid stays 0. After release, an impulse of 777 on ch1 yields exactly 777.
